// File: rtl/zeroriscy_soc_pkg.sv
// zeroriscy_soc shared types: core FSM states, status flag bit
// indices and the instruction address step.
package zeroriscy_soc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WB,
    DONE
  } core_state_e;

  localparam int FLAG_C1_WR    = 0;
  localparam int FLAG_C2_WR    = 1;
  localparam int FLAG_MATCH    = 2;
  localparam int FLAG_MISMATCH = 3;

  localparam logic [31:0] INSTR_STEP = 32'd4;

endpackage

// File: rtl/zeroriscy_soc_if.sv
// Core-to-arbiter result write channel.
// master: req/data out, gnt in; slave: the reverse.
interface zeroriscy_soc_if;

  logic        req;
  logic        gnt;
  logic [31:0] data;

  modport master (
    output req,
    output data,
    input  gnt
  );

  modport slave (
    input  req,
    input  data,
    output gnt
  );

endinterface

// File: rtl/zeroriscy_soc_core.sv
// zr_mini_core: summation sequencer with result write-back.
// Ports: clk_i, rst_i, en_i, [fault_i if ZR_SOC_FAULT_INJECT_EN], wr, acc_o, addr_o.
module zr_mini_core
  import zeroriscy_soc_pkg::*;
#(
  parameter int          N_ITER    = 10,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
`ifdef ZR_SOC_FAULT_INJECT_EN
  input  logic         fault_i,
`endif
  zeroriscy_soc_if.master wr,
  output logic [31:0]  acc_o,
  output logic [31:0]  addr_o
);

  localparam logic [7:0] LAST = 8'(N_ITER);

  core_state_e state;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nx;
  logic [31:0] acc;
  logic [31:0] addr;
  logic [31:0] sum;
  logic        req_q;

  always_comb begin
    cnt_nx = cnt + 8'd1;
    sum    = acc + {24'd0, cnt_nx};
`ifdef ZR_SOC_FAULT_INJECT_EN
    if (state == RUN && fault_i)
      sum = sum ^ 32'h1;
`endif
  end

  // IDLE shares the RUN datapath: the enabling
  // cycle already performs iteration 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= 8'd0;
      acc   <= 32'd0;
      addr  <= BOOT_ADDR;
      req_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE, RUN: begin
          if (en_i) begin
            cnt  <= cnt_nx;
            acc  <= sum;
            addr <= addr + INSTR_STEP;
            if (cnt_nx == LAST) begin
              state <= WB;
              req_q <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        WB: begin
          if (wr.gnt) begin
            state <= DONE;
            req_q <= 1'b0;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign wr.req  = req_q;
  assign wr.data = acc;
  assign acc_o   = acc;
  assign addr_o  = addr;

endmodule

// File: rtl/zeroriscy_soc.sv
// Dual-core SoC: two zr_mini_core, fixed-priority write arbiter,
// two-word result memory and result comparator. Ports: clk_i,
// rst_ni (active-high), fetch_enable_i_1/2, [fault_inject_i if
// ZR_SOC_FAULT_INJECT_EN], alu_result_c1/2, mem_flag, mem_result,
// instr_addr1/2.
module zeroriscy_soc
  import zeroriscy_soc_pkg::*;
#(
  parameter int          N_ITER    = 10,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i_1,
  input  logic        fetch_enable_i_2,
`ifdef ZR_SOC_FAULT_INJECT_EN
  input  logic        fault_inject_i,
`endif
  output logic [31:0] alu_result_c1,
  output logic [31:0] alu_result_c2,
  output logic [31:0] mem_flag,
  output logic [31:0] mem_result,
  output logic [31:0] instr_addr1,
  output logic [31:0] instr_addr2
);

  zeroriscy_soc_if c1_if ();
  zeroriscy_soc_if c2_if ();

  logic [31:0] mem_q [2];
  logic [3:0]  flag_q;
  logic [31:0] res_q;
  logic        both_wr;
  logic        decided;

  zr_mini_core #(
    .N_ITER    (N_ITER),
    .BOOT_ADDR (BOOT_ADDR)
  ) u_core1 (
    .clk_i   (clk_i),
    .rst_i   (rst_ni),
    .en_i    (fetch_enable_i_1),
`ifdef ZR_SOC_FAULT_INJECT_EN
    .fault_i (1'b0),
`endif
    .wr      (c1_if),
    .acc_o   (alu_result_c1),
    .addr_o  (instr_addr1)
  );

  zr_mini_core #(
    .N_ITER    (N_ITER),
    .BOOT_ADDR (BOOT_ADDR)
  ) u_core2 (
    .clk_i   (clk_i),
    .rst_i   (rst_ni),
    .en_i    (fetch_enable_i_2),
`ifdef ZR_SOC_FAULT_INJECT_EN
    .fault_i (fault_inject_i),
`endif
    .wr      (c2_if),
    .acc_o   (alu_result_c2),
    .addr_o  (instr_addr2)
  );

  // Core 1 has fixed priority; core 2 holds its
  // request and is served once core 1 drops.
  assign c1_if.gnt = c1_if.req;
  assign c2_if.gnt = c2_if.req & ~c1_if.req;

  assign both_wr = flag_q[FLAG_C1_WR] & flag_q[FLAG_C2_WR];
  assign decided = flag_q[FLAG_MATCH] | flag_q[FLAG_MISMATCH];

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      mem_q[0] <= 32'd0;
      mem_q[1] <= 32'd0;
      flag_q   <= 4'd0;
      res_q    <= 32'd0;
    end else begin
      if (c1_if.gnt) begin
        mem_q[0]           <= c1_if.data;
        flag_q[FLAG_C1_WR] <= 1'b1;
      end else if (c2_if.gnt) begin
        mem_q[1]           <= c2_if.data;
        flag_q[FLAG_C2_WR] <= 1'b1;
      end
      if (both_wr && !decided) begin
        if (mem_q[0] == mem_q[1]) begin
          flag_q[FLAG_MATCH] <= 1'b1;
          res_q              <= mem_q[0];
        end else begin
          flag_q[FLAG_MISMATCH] <= 1'b1;
        end
      end
    end
  end

  assign mem_flag   = {28'd0, flag_q};
  assign mem_result = res_q;

endmodule

// File: tb/tb_zeroriscy_soc.sv
// Self-checking bench for zeroriscy_soc (N_ITER=10 and N_ITER=1).
// Status-flag transitions are checked against a queue of expected events.
module tb_zeroriscy_soc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en1 = 1'b0;
  logic en2 = 1'b0;
  logic enb = 1'b0;
  logic fault = 1'b0;

  logic [31:0] acc1, acc2, flag, res, addr1, addr2;
  logic [31:0] acc1_b, acc2_b, flag_b, res_b, addr1_b, addr2_b;

  always #5 clk = ~clk;

  zeroriscy_soc u_dut (
    .clk_i            (clk),
    .rst_ni           (rst),
    .fetch_enable_i_1 (en1),
    .fetch_enable_i_2 (en2),
`ifdef ZR_SOC_FAULT_INJECT_EN
    .fault_inject_i   (fault),
`endif
    .alu_result_c1    (acc1),
    .alu_result_c2    (acc2),
    .mem_flag         (flag),
    .mem_result       (res),
    .instr_addr1      (addr1),
    .instr_addr2      (addr2)
  );

  zeroriscy_soc #(.N_ITER(1)) u_dut1 (
    .clk_i            (clk),
    .rst_ni           (rst),
    .fetch_enable_i_1 (enb),
    .fetch_enable_i_2 (enb),
`ifdef ZR_SOC_FAULT_INJECT_EN
    .fault_inject_i   (1'b0),
`endif
    .alu_result_c1    (acc1_b),
    .alu_result_c2    (acc2_b),
    .mem_flag         (flag_b),
    .mem_result       (res_b),
    .instr_addr1      (addr1_b),
    .instr_addr2      (addr2_b)
  );

  typedef struct {
    logic [3:0]  flag;
    logic [31:0] res;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  cyc = 0;
  logic [3:0] prev_flag = 4'd0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Flags only fall on reset, so any nonzero change is a DUT event.
  always @(negedge clk) begin
    if (flag[3:0] != prev_flag && flag[3:0] != 4'd0) begin
      if (exp_q.size() == 0) begin
        chk("flag_unexpected", flag, {28'd0, prev_flag});
      end else begin
        ev_t ev;
        ev = exp_q.pop_front();
        chk("flag", flag, {28'd0, ev.flag});
        chk("result", res, ev.res);
        chk("flag_cycle", 32'(cyc), 32'(ev.cyc));
      end
    end
    prev_flag = flag[3:0];
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(logic [3:0] f, logic [31:0] r, int c);
    ev_t ev;
    ev.flag = f;
    ev.res  = r;
    ev.cyc  = c;
    exp_q.push_back(ev);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    step(1);
    chk("rst_acc1", acc1, 32'd0);
    chk("rst_acc2", acc2, 32'd0);
    chk("rst_addr1", addr1, 32'h80);
    chk("rst_addr2", addr2, 32'h80);
    chk("rst_flag", flag, 32'd0);
    chk("rst_result", res, 32'd0);
    chk("rst_b_flag", flag_b, 32'd0);
    rst = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      step(1);
      t++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    // Lock-step run of both cores.
    en1 = 1'b1;
    en2 = 1'b1;
    do_reset();
    push(4'b0001, 32'd0, 11);
    push(4'b0011, 32'd0, 12);
    push(4'b0111, 32'd55, 13);
    step(10);
    chk("run_acc1", acc1, 32'd55);
    chk("run_acc2", acc2, 32'd55);
    chk("run_addr1", addr1, 32'hA8);
    chk("run_addr2", addr2, 32'hA8);
    drain();
    step(3);
    chk("sticky_flag", flag, 32'h7);
    chk("sticky_result", res, 32'd55);
    chk("done_acc1", acc1, 32'd55);
    chk("done_addr2", addr2, 32'hA8);

    // Core 2 stalled for 5 cycles after 3 iterations.
    do_reset();
    push(4'b0001, 32'd0, 11);
    push(4'b0011, 32'd0, 16);
    push(4'b0111, 32'd55, 17);
    step(3);
    chk("stall_acc2_pre", acc2, 32'd6);
    en2 = 1'b0;
    step(5);
    chk("stall_acc2", acc2, 32'd6);
    chk("stall_addr2", addr2, 32'h8C);
    chk("stall_acc1", acc1, 32'd36);
    chk("stall_addr1", addr1, 32'hA0);
    en2 = 1'b1;
    step(2);
    chk("stall_acc1_end", acc1, 32'd55);
    chk("stall_acc2_mid", acc2, 32'd15);
    chk("stall_addr2_mid", addr2, 32'h94);
    step(1);
    chk("stall_c1_only", flag, 32'h1);
    drain();
    chk("stall_acc2_end", acc2, 32'd55);

    // Reset in the middle of a run.
    do_reset();
    step(4);
    chk("mid_acc1", acc1, 32'd10);
    chk("mid_addr2", addr2, 32'h90);
    do_reset();
    push(4'b0001, 32'd0, 11);
    push(4'b0011, 32'd0, 12);
    push(4'b0111, 32'd55, 13);
    step(10);
    chk("rerun_acc1", acc1, 32'd55);
    chk("rerun_acc2", acc2, 32'd55);
    drain();

`ifdef ZR_SOC_FAULT_INJECT_EN
    // Single fault pulse on core 2 iteration 2.
    do_reset();
    push(4'b0001, 32'd0, 11);
    push(4'b0011, 32'd0, 12);
    push(4'b1011, 32'd0, 13);
    step(1);
    fault = 1'b1;
    step(1);
    fault = 1'b0;
    step(8);
    chk("fault_acc1", acc1, 32'd55);
    chk("fault_acc2", acc2, 32'd54);
    drain();
`endif

    // N_ITER=1 instance; main instance left idle.
    en1 = 1'b0;
    en2 = 1'b0;
    do_reset();
    enb = 1'b1;
    step(1);
    chk("n1_acc1", acc1_b, 32'd1);
    chk("n1_acc2", acc2_b, 32'd1);
    chk("n1_addr1", addr1_b, 32'h84);
    chk("n1_addr2", addr2_b, 32'h84);
    step(1);
    chk("n1_flag_c1", flag_b, 32'h1);
    step(2);
    chk("n1_flag", flag_b, 32'h7);
    chk("n1_result", res_b, 32'd1);
    chk("idle_hold_acc1", acc1, 32'd0);
    chk("idle_hold_addr2", addr2, 32'h80);
    chk("idle_hold_flag", flag, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
